// File: rtl/parking_gate_ctrl_if.sv
// Bundle between the sensor/keypad front end and the gate controller.
// The master side drives sensors, keypad and PIN table; the slave side drives actuator/alarm outputs.
interface parking_gate_ctrl_if #(
   parameter int PIN_W     = 16,
   parameter int N_USERS   = 4,
   parameter int MAX_TRIES = 3
);
   localparam int CNT_W = $clog2(MAX_TRIES + 1);
   localparam int UID_W = $clog2(N_USERS);

   logic                     car_arrive;
   logic                     car_pass;
   logic                     pin_valid;
   logic [PIN_W-1:0]         pin;
   logic [N_USERS*PIN_W-1:0] user_pins;
   logic [PIN_W-1:0]         admin_pin;
   logic                     gate_open;
   logic                     wrong_pin_alarm;
   logic                     lock_alarm;
   logic                     gate_timeout;
   logic [CNT_W-1:0]         fail_cnt;
   logic [UID_W-1:0]         user_id;

   modport master (
      output car_arrive, car_pass, pin_valid, pin, user_pins, admin_pin,
      input  gate_open, wrong_pin_alarm, lock_alarm, gate_timeout, fail_cnt, user_id
   );
   modport slave (
      input  car_arrive, car_pass, pin_valid, pin, user_pins, admin_pin,
      output gate_open, wrong_pin_alarm, lock_alarm, gate_timeout, fail_cnt, user_id
   );
endinterface

// File: rtl/parking_gate_ctrl.sv
// Parking entrance gate controller: PIN check against a user table, failure lockout with
// admin recovery, tailgate blocking and a timed auto-close of the open gate.
module parking_gate_ctrl #(
   parameter int PIN_W       = 16,
   parameter int N_USERS     = 4,
   parameter int MAX_TRIES   = 3,
   parameter int WARN_AT     = 2,
   parameter int OPEN_CYCLES = 8
) (
   input logic            clk,
   input logic            rst,
   parking_gate_ctrl_if.slave gif
);
   localparam int CNT_W = $clog2(MAX_TRIES + 1);
   localparam int UID_W = $clog2(N_USERS);
   localparam int TMR_W = $clog2(OPEN_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, WAIT_PIN, OPEN, BLOCKED} state_t;

   state_t           state, state_nxt;
   logic [TMR_W-1:0] timer, timer_nxt;
   logic [CNT_W-1:0] fail_cnt, fail_nxt, fail_inc;
   logic [UID_W-1:0] user_id, uid_nxt, hit_idx;
   logic             warn, warn_nxt, tmo, tmo_nxt;
   logic [N_USERS-1:0] hit;

   for (genvar k = 0; k < N_USERS; k++) begin : g_slot
      assign hit[k] = (gif.user_pins[k*PIN_W +: PIN_W] == gif.pin);
   end

   // Duplicate PINs resolve to the lowest slot.
   always_comb begin
      hit_idx = '0;
      for (int k = N_USERS - 1; k >= 0; k--)
         if (hit[k]) hit_idx = UID_W'(k);
   end

   // Saturating increment; reaching MAX_TRIES always leaves WAIT_PIN, so this is belt-and-braces.
   assign fail_inc = (fail_cnt == CNT_W'(MAX_TRIES)) ? fail_cnt : fail_cnt + CNT_W'(1);

   always_comb begin
      state_nxt = state;
      timer_nxt = '0;
      fail_nxt  = fail_cnt;
      warn_nxt  = warn;
      uid_nxt   = user_id;
      tmo_nxt   = 1'b0;
      unique case (state)
         IDLE: begin
            if (gif.car_arrive) state_nxt = gif.car_pass ? BLOCKED : WAIT_PIN;
         end
         WAIT_PIN: begin
            if (gif.car_pass) begin
               state_nxt = BLOCKED;
            end else if (gif.pin_valid) begin
               if (|hit) begin
                  state_nxt = OPEN;
                  fail_nxt  = '0;
                  warn_nxt  = 1'b0;
                  uid_nxt   = hit_idx;
               end else begin
                  fail_nxt = fail_inc;
                  warn_nxt = (fail_inc >= CNT_W'(WARN_AT));
                  if (fail_inc == CNT_W'(MAX_TRIES)) state_nxt = BLOCKED;
               end
            end
         end
         OPEN: begin
            if (gif.car_pass) begin
               state_nxt = IDLE;
            end else if (timer == TMR_W'(OPEN_CYCLES - 1)) begin
               state_nxt = IDLE;
               tmo_nxt   = 1'b1;
            end else begin
               timer_nxt = timer + TMR_W'(1);
            end
         end
         BLOCKED: begin
            if (gif.pin_valid && gif.pin == gif.admin_pin) begin
               state_nxt = IDLE;
               fail_nxt  = '0;
               warn_nxt  = 1'b0;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         timer    <= '0;
         fail_cnt <= '0;
         warn     <= 1'b0;
         user_id  <= '0;
         tmo      <= 1'b0;
      end else begin
         state    <= state_nxt;
         timer    <= timer_nxt;
         fail_cnt <= fail_nxt;
         warn     <= warn_nxt;
         user_id  <= uid_nxt;
         tmo      <= tmo_nxt;
      end
   end

   assign gif.gate_open       = (state == OPEN);
   assign gif.lock_alarm      = (state == BLOCKED);
   assign gif.wrong_pin_alarm = warn;
   assign gif.gate_timeout    = tmo;
   assign gif.fail_cnt        = fail_cnt;
   assign gif.user_id         = user_id;
endmodule
